// File: rtl/scroll_message_driver.sv
// scroll_message_driver: scrolls a 4-bit-character ROM message across a
// multiplexed, active-low 7-segment display. A debounced push-button steps
// the start index forward or backward.
// Optional feature macro: AUTO_SCROLL_EN adds auto_en / AUTO_PERIOD, which
// provide a periodic step that is merged with the button step.
module scroll_message_driver #(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned MSG_LEN         = 16,
   parameter int unsigned REFRESH_DIV     = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 65536
`ifdef AUTO_SCROLL_EN
   ,parameter int unsigned AUTO_PERIOD    = 50000000
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       button,
   input  logic                       dir,
`ifdef AUTO_SCROLL_EN
   input  logic                       auto_en,
`endif
   output logic [NUM_DIGITS-1:0]      an,
   output logic [6:0]                 seg,
   output logic                       dp,
   output logic [$clog2(MSG_LEN)-1:0] pos
);

   localparam int unsigned PW = $clog2(MSG_LEN);
   localparam int unsigned SW = $clog2(NUM_DIGITS);
   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Message ROM: address k holds k mod 16.
   function automatic logic [3:0] msg_rom(input logic [PW-1:0] addr);
      return 4'(addr);
   endfunction

   // Hex digit to active-low {a,b,c,d,e,f,g} glyph.
   function automatic logic [6:0] hex_glyph(input logic [3:0] chr);
      logic [6:0] g;
      case (chr)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;
         4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;
         4'hF: g = 7'b0111000;
      endcase
      return g;
   endfunction

   logic [1:0]            rst_sync_q, rst_sync_d;
   logic                  rst_i;
   logic                  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic                  db_level_q, db_level_d;
   logic [DW-1:0]         db_cnt_q, db_cnt_d;
   logic                  step_q, step_d;
   logic                  any_step;
   logic [PW-1:0]         pos_q, pos_d;
   scan_state_e           state_q, state_d;
   logic [CW-1:0]         pre_q, pre_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  tick;
   logic [PW-1:0]         char_addr;

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = 1'b1;
   assign pos   = pos_q;
   assign rst_i = rst_sync_q[1];

   // Reset asserts immediately and releases two clocks after the pin drops.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_sync_q <= 2'b11;
      else       rst_sync_q <= rst_sync_d;
   end

   // Button synchroniser, debouncer and rising-edge step pulse.
   always_comb begin
      btn_s1_d   = button;
      btn_s2_d   = btn_s1_q;
      db_level_d = db_level_q;
      db_cnt_d   = '0;
      if (btn_s2_q != db_level_q) begin
         if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) db_level_d = ~db_level_q;
         else                                      db_cnt_d   = db_cnt_q + DW'(1);
      end
      step_d = db_level_d & ~db_level_q;
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         db_level_q <= 1'b0;
         db_cnt_q   <= '0;
         step_q     <= 1'b0;
      end else begin
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         db_level_q <= db_level_d;
         db_cnt_q   <= db_cnt_d;
         step_q     <= step_d;
      end
   end

`ifdef AUTO_SCROLL_EN
   localparam int unsigned AW = $clog2(AUTO_PERIOD + 1);

   logic [AW-1:0] auto_cnt_q, auto_cnt_d;
   logic          auto_step;

   // Periodic auto-step timer; restarts when disabled or on a button step.
   always_comb begin
      auto_step  = auto_en && (auto_cnt_q == AW'(AUTO_PERIOD - 1));
      auto_cnt_d = auto_cnt_q + AW'(1);
      if (!auto_en || step_q || auto_step) auto_cnt_d = '0;
      any_step   = step_q | auto_step;
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) auto_cnt_q <= '0;
      else       auto_cnt_q <= auto_cnt_d;
   end
`else
   // Only the button can step the message.
   always_comb any_step = step_q;
`endif

   // Message start index, wrapping modulo MSG_LEN in either direction.
   always_comb begin
      pos_d = pos_q;
      if (any_step) pos_d = dir ? (pos_q - PW'(1)) : (pos_q + PW'(1));
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) pos_q <= '0;
      else       pos_q <= pos_d;
   end

   // Scan sequencer: one BLANK cycle then REFRESH_DIV-1 DRIVE cycles per digit.
   always_comb begin
      state_d   = state_q;
      an_d      = an_q;
      seg_d     = seg_q;
      tick      = (pre_q == CW'(REFRESH_DIV - 1));
      pre_d     = tick ? '0 : (pre_q + CW'(1));
      scan_d    = scan_q;
      char_addr = pos_q + PW'(NUM_DIGITS - 1) - PW'(scan_q);
      if (tick) scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : (scan_q + SW'(1));
      case (state_q)
         ST_BLANK: begin
            state_d = ST_DRIVE;
            an_d    = ~(NUM_DIGITS'(1) << scan_q);
            seg_d   = hex_glyph(msg_rom(char_addr));
         end
         ST_DRIVE: begin
            if (tick) begin
               state_d = ST_BLANK;
               an_d    = '1;
               seg_d   = '1;
            end
         end
         default: begin
            state_d = ST_BLANK;
            an_d    = '1;
            seg_d   = '1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_BLANK;
         pre_q   <= '0;
         scan_q  <= '0;
         an_q    <= '1;
         seg_q   <= '1;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         scan_q  <= scan_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

endmodule

// File: tb/tb_scroll_message_driver.sv
// Directed bench for scroll_message_driver with small timing parameters.
module tb_scroll_message_driver;

   localparam int unsigned ND = 4;
   localparam int unsigned ML = 16;
   localparam int unsigned RD = 4;
   localparam int unsigned DC = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          button;
   logic          dir;
`ifdef AUTO_SCROLL_EN
   logic          auto_en;
`endif
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    pos;

   int n_cmp = 0;
   int n_bad = 0;

   scroll_message_driver #(
      .NUM_DIGITS     (ND),
      .MSG_LEN        (ML),
      .REFRESH_DIV    (RD),
      .DEBOUNCE_CYCLES(DC)
`ifdef AUTO_SCROLL_EN
      ,.AUTO_PERIOD   (10)
`endif
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .button (button),
      .dir    (dir),
`ifdef AUTO_SCROLL_EN
      .auto_en(auto_en),
`endif
      .an     (an),
      .seg    (seg),
      .dp     (dp),
      .pos    (pos)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press();
      button = 1'b1;
      cycles(20);
      button = 1'b0;
      cycles(20);
   endtask

   task automatic wait_an(input logic [3:0] pat, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (an == pat) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_drive(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (an != 4'b1111) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_digit(input string tag, input int idx, input logic [6:0] exp_seg);
      logic [3:0] pat;
      bit         ok;
      pat = ~(4'(1) << idx);
      wait_an(pat, ok);
      if (!ok) check_eq({tag, "_timeout"}, 32'(an), 32'(pat));
      else     check_eq(tag, 32'(seg), 32'(exp_seg));
   endtask

   logic [3:0] exp_an [16];
   bit         ok;

   initial begin
      exp_an = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                 4'b1101, 4'b1101, 4'b1101, 4'b1111,
                 4'b1011, 4'b1011, 4'b1011, 4'b1111,
                 4'b0111, 4'b0111, 4'b0111, 4'b1111};
      reset  = 1'b1;
      button = 1'b0;
      dir    = 1'b0;
`ifdef AUTO_SCROLL_EN
      auto_en = 1'b0;
`endif
      cycles(3);
      check_eq("rst_an",  32'(an),  32'h0000000F);
      check_eq("rst_seg", 32'(seg), 32'h0000007F);
      check_eq("rst_pos", 32'(pos), 32'h00000000);
      check_eq("dp",      32'(dp),  32'h00000001);

      // Idle scan pattern after release: first slot is digit 0
      reset = 1'b0;
      wait_drive(ok);
      if (!ok) check_eq("scan_start_timeout", 32'(an), 32'h0000000E);
      for (int i = 0; i < 16; i++) begin
         check_eq("an_seq", 32'(an), 32'(exp_an[i]));
         if (exp_an[i] == 4'b1111) check_eq("blank_seg", 32'(seg), 32'h0000007F);
         cycles(1);
      end
      cycles(20);
      check_eq("idle_pos", 32'(pos), 32'h0);
      check_digit("idle_d3", 3, 7'b0000001);
      check_digit("idle_d0", 0, 7'b0000110);

      // Short glitch rejected, long press gives exactly one step
      button = 1'b1;
      cycles(5);
      button = 1'b0;
      cycles(20);
      check_eq("short_press_pos", 32'(pos), 32'h0);
      press();
      check_eq("long_press_pos", 32'(pos), 32'h1);
      check_digit("pos1_d0", 0, 7'b1001100);

      // Backward steps including 0 -> 15 wrap
      dir = 1'b1;
      press();
      check_eq("back_pos0", 32'(pos), 32'h0);
      press();
      check_eq("back_wrap", 32'(pos), 32'hF);
      check_digit("pos15_d3", 3, 7'b0111000);
      check_digit("pos15_d2", 2, 7'b0000001);
      check_digit("pos15_d1", 1, 7'b1001111);
      check_digit("pos15_d0", 0, 7'b0010010);

      // Forward wrap 15 -> 0, then a full lap of 16 presses
      dir = 1'b0;
      press();
      check_eq("fwd_wrap", 32'(pos), 32'h0);
      for (int i = 0; i < 16; i++) press();
      check_eq("full_lap", 32'(pos), 32'h0);

      // Reset during a DRIVE slot with a press half-debounced
      press();
      check_eq("pre_rst_pos", 32'(pos), 32'h1);
      button = 1'b1;
      cycles(5);
      wait_drive(ok);
      check_eq("mid_drive", 32'(ok), 32'h1);
      reset = 1'b1;
      #1;
      check_eq("async_rst_an",  32'(an),  32'h0000000F);
      check_eq("async_rst_seg", 32'(seg), 32'h0000007F);
      check_eq("async_rst_pos", 32'(pos), 32'h0);
      @(negedge clk);
      button = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(40);
      check_eq("post_rst_pos", 32'(pos), 32'h0);
      check_digit("post_rst_d0", 0, 7'b0000110);

`ifdef AUTO_SCROLL_EN
      // Auto step every 10 cycles
      auto_en = 1'b1;
      cycles(35);
      auto_en = 1'b0;
      cycles(2);
      check_eq("auto_pos", 32'(pos), 32'h3);
      // Button step and auto step landing on the same cycle count once
      button = 1'b1;
      cycles(1);
      auto_en = 1'b1;
      cycles(10);
      auto_en = 1'b0;
      cycles(10);
      button = 1'b0;
      cycles(20);
      check_eq("coincide_pos", 32'(pos), 32'h4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
